// File: rtl/rgb_fade_ctrl_pkg.sv
// rgb_fade_ctrl_pkg
//   Shared definitions for the RGB fade sequencer and the SPI command decoder
//   that feeds it: FSM state encoding, default widths, and the "set fade"
//   opcode the decoder recognises before forwarding a command here.
package rgb_fade_ctrl_pkg;

    localparam int LVL_W_DEF  = 12;
    localparam int RATE_W_DEF = 16;
    localparam int STEP_DEF   = 1;

    // SPI opcode decoded upstream into a cmd_valid pulse on this block.
    localparam logic [7:0] OPC_SET_FADE = 8'hF5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

endpackage

// File: rtl/rgb_fade_ctrl_fade_channel.sv
// fade_channel
//   One colour channel of the fade sequencer. Holds the latched target and
//   the current level, and moves the level one step toward the target on
//   each tick without overshooting or wrapping.
// Ports
//   clk, resetq  clock, asynchronous active-low reset
//   load         latch 'target' (only asserted while the sequencer is idle)
//   target       new target level
//   tick         apply one step this cycle
//   level        current level (registered)
//   at_target    level already equals the latched target
//   final_step   not yet at target, but the next tick lands exactly on it
module fade_channel #(
    parameter int LVL_W = 12,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             load,
    input  logic [LVL_W-1:0] target,
    input  logic             tick,
    output logic [LVL_W-1:0] level,
    output logic             at_target,
    output logic             final_step
);

    logic [LVL_W-1:0] target_q;
    logic [LVL_W-1:0] level_q, level_d;

    // One bit of headroom so level +/- STEP never wraps during comparison.
    logic [LVL_W:0] lvl_x, tgt_x, step_x, diff_x;

    assign lvl_x  = {1'b0, level_q};
    assign tgt_x  = {1'b0, target_q};
    assign step_x = (LVL_W + 1)'(STEP);
    assign diff_x = (tgt_x >= lvl_x) ? (tgt_x - lvl_x) : (lvl_x - tgt_x);

    assign at_target  = (level_q == target_q);
    assign final_step = !at_target && (diff_x <= step_x);

    always_comb begin
        level_d = level_q;
        if (tick) begin
            if (diff_x <= step_x) begin
                // Within one step: snap to target so the endpoints are exact.
                level_d = target_q;
            end else if (tgt_x > lvl_x) begin
                level_d = LVL_W'(lvl_x + step_x);
            end else begin
                level_d = LVL_W'(lvl_x - step_x);
            end
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            target_q <= '0;
            level_q  <= '0;
        end else begin
            if (load) begin
                target_q <= target;
            end
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/rgb_fade_ctrl.sv
// rgb_fade_ctrl
//   Sequencer in front of the three RGB sigma-delta modulators. Accepts a
//   target colour and a step rate, ramps each channel linearly toward its
//   target one step per prescaler tick, and pulses done_stb on completion.
// Ports
//   clk, resetq           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (see below)
//   cmd_rgb               targets {blue, green, red}, red in the LSBs
//   cmd_rate              clk cycles between steps minus 1
//   level_red/grn/blu     registered channel levels to the modulators
//   busy                  high while ramping
//   done_stb              one-cycle pulse when all levels reach target
//   dbg_state             current FSM state
//
// Handshake: a command transfers on the rising edge where cmd_valid and
// cmd_ready are both high; cmd_rgb/cmd_rate are sampled only on that edge.
// cmd_ready is high exactly in IDLE, so a master holding cmd_valid through a
// ramp is accepted in the first IDLE cycle (the one carrying done_stb).
module rgb_fade_ctrl
    import rgb_fade_ctrl_pkg::*;
#(
    parameter int LVL_W  = LVL_W_DEF,
    parameter int STEP   = STEP_DEF,
    parameter int RATE_W = RATE_W_DEF
) (
    input  logic               clk,
    input  logic               resetq,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3*LVL_W-1:0] cmd_rgb,
    input  logic [RATE_W-1:0]  cmd_rate,
    output logic [LVL_W-1:0]   level_red,
    output logic [LVL_W-1:0]   level_grn,
    output logic [LVL_W-1:0]   level_blu,
    output logic               busy,
    output logic               done_stb,
    output state_t             dbg_state
);

    state_t              state_q, state_d;
    logic [RATE_W-1:0]   presc_q, presc_d;
    logic [RATE_W-1:0]   rate_q, rate_d;
    logic                done_q, done_d;
    logic                load, tick;

    logic [2:0][LVL_W-1:0] lvl;
    logic [2:0]            at_tgt, fin_step;
    logic                  cmd_eq;

    for (genvar i = 0; i < 3; i++) begin : g_ch
        fade_channel #(
            .LVL_W (LVL_W),
            .STEP  (STEP)
        ) u_ch (
            .clk        (clk),
            .resetq     (resetq),
            .load       (load),
            .target     (cmd_rgb[i*LVL_W +: LVL_W]),
            .tick       (tick),
            .level      (lvl[i]),
            .at_target  (at_tgt[i]),
            .final_step (fin_step[i])
        );
    end

    // Packed lvl places channel 2 (blue) in the MSBs, matching cmd_rgb.
    assign cmd_eq = (cmd_rgb == lvl);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        rate_d  = rate_q;
        done_d  = 1'b0;
        load    = 1'b0;
        tick    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_eq) begin
                        // Nothing to ramp: acknowledge straight away.
                        done_d = 1'b1;
                    end else begin
                        load    = 1'b1;
                        rate_d  = cmd_rate;
                        presc_d = cmd_rate;
                        state_d = ST_RAMP;
                    end
                end
            end
            ST_RAMP: begin
                if (presc_q == '0) begin
                    tick    = 1'b1;
                    presc_d = rate_q;
                    // Levels update on this same edge, so finish now if every
                    // channel is either done already or lands on this tick.
                    if (&(at_tgt | fin_step)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    presc_d = presc_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            rate_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            rate_q  <= rate_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RAMP);
    assign done_stb  = done_q;
    assign dbg_state = state_q;
    assign level_red = lvl[0];
    assign level_grn = lvl[1];
    assign level_blu = lvl[2];

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
module tb_rgb_fade_ctrl;
    import rgb_fade_ctrl_pkg::*;

    localparam int LW = 12;
    localparam int RW = 16;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic resetq = 1'b0;
    always #5 clk = ~clk;

    // DUT with STEP=1
    logic            v1    = 1'b0;
    logic [3*LW-1:0] rgb1  = '0;
    logic [RW-1:0]   rate1 = '0;
    logic            rdy1, busy1, done1;
    logic [LW-1:0]   r1, g1, b1;
    state_t          st1;

    // DUT with STEP=5
    logic            v5    = 1'b0;
    logic [3*LW-1:0] rgb5  = '0;
    logic [RW-1:0]   rate5 = '0;
    logic            rdy5, busy5, done5;
    logic [LW-1:0]   r5, g5, b5;
    state_t          st5;

    int n_cmp = 0;
    int n_err = 0;

    rgb_fade_ctrl #(.LVL_W(LW), .STEP(1), .RATE_W(RW)) dut (
        .clk(clk), .resetq(resetq), .cmd_valid(v1), .cmd_ready(rdy1),
        .cmd_rgb(rgb1), .cmd_rate(rate1), .level_red(r1), .level_grn(g1),
        .level_blu(b1), .busy(busy1), .done_stb(done1), .dbg_state(st1)
    );

    rgb_fade_ctrl #(.LVL_W(LW), .STEP(5), .RATE_W(RW)) dut5 (
        .clk(clk), .resetq(resetq), .cmd_valid(v5), .cmd_ready(rdy5),
        .cmd_rgb(rgb5), .cmd_rate(rate5), .level_red(r5), .level_grn(g5),
        .level_blu(b5), .busy(busy5), .done_stb(done5), .dbg_state(st5)
    );

    // ---------------- driver ----------------
    // Called at a negedge while the selected DUT is idle; returns at the
    // negedge of cycle 1 (first cycle after the transfer edge).
    task automatic send_cmd(input int sel, input logic [3*LW-1:0] rgb, input logic [RW-1:0] rate);
        if (sel == 0) begin
            v1 = 1'b1; rgb1 = rgb; rate1 = rate;
        end else begin
            v5 = 1'b1; rgb5 = rgb; rate5 = rate;
        end
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0;
        v5 = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        resetq = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({r1, g1, b1, rdy1, busy1, done1, st1} !== {36'h0, 3'b100, ST_IDLE}) begin
            n_err++;
            $display("FAIL reset_dut1: got %h/%b%b%b expected 0/100", {r1, g1, b1}, rdy1, busy1, done1);
        end
        n_cmp++;
        if ({r5, g5, b5, rdy5, busy5, done5, st5} !== {36'h0, 3'b100, ST_IDLE}) begin
            n_err++;
            $display("FAIL reset_dut5: got %h/%b%b%b expected 0/100", {r5, g5, b5}, rdy5, busy5, done5);
        end
        resetq = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ramp_up();
        int pulses;
        logic [LW-1:0] exp_r;
        logic exp_done, exp_busy;
        pulses = 0;
        send_cmd(0, {12'h000, 12'h000, 12'h100}, 16'd0);
        n_cmp++;
        if ({busy1, rdy1, done1, r1, st1} !== {3'b100, 12'h000, ST_RAMP}) begin
            n_err++;
            $display("FAIL ramp_up_entry: got busy=%b rdy=%b done=%b red=%h expected 1 0 0 000",
                     busy1, rdy1, done1, r1);
        end
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            exp_r    = 12'(k);
            exp_done = (k == 256);
            exp_busy = (k != 256);
            if (done1) pulses++;
            n_cmp++;
            if ({r1, g1, b1, done1, busy1} !== {exp_r, 24'h0, exp_done, exp_busy}) begin
                n_err++;
                $display("FAIL ramp_up k=%0d: got red=%h grn=%h blu=%h done=%b busy=%b expected red=%h 0 0 done=%b busy=%b",
                         k, r1, g1, b1, done1, busy1, exp_r, exp_done, exp_busy);
            end
        end
        @(negedge clk);
        if (done1) pulses++;
        n_cmp++;
        if ({done1, busy1, rdy1, r1} !== {3'b001, 12'h100}) begin
            n_err++;
            $display("FAIL ramp_up_after: got done=%b busy=%b rdy=%b red=%h expected 0 0 1 100",
                     done1, busy1, rdy1, r1);
        end
        n_cmp++;
        if (pulses !== 1) begin
            n_err++;
            $display("FAIL ramp_up_pulses: got %0d done pulses expected 1", pulses);
        end
    endtask

    task automatic test_ramp_down();
        logic [LW-1:0] exp_r;
        logic exp_done, exp_busy;
        send_cmd(0, {12'h000, 12'h000, 12'h0FE}, 16'd3);
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) @(negedge clk);
            exp_r    = (c <= 4) ? 12'h100 : (c <= 8) ? 12'h0FF : 12'h0FE;
            exp_done = (c == 9);
            exp_busy = (c <= 8);
            n_cmp++;
            if ({r1, g1, b1, done1, busy1} !== {exp_r, 24'h0, exp_done, exp_busy}) begin
                n_err++;
                $display("FAIL ramp_down c=%0d: got red=%h done=%b busy=%b expected red=%h done=%b busy=%b",
                         c, r1, done1, busy1, exp_r, exp_done, exp_busy);
            end
        end
    endtask

    task automatic test_step_clamp();
        logic [LW-1:0] exp_b;
        logic exp_done, exp_busy;
        logic [LW-1:0] up_tab[5];
        logic [LW-1:0] dn_tab[5];
        up_tab = '{12'h000, 12'h005, 12'h00A, 12'h00B, 12'h00B};
        dn_tab = '{12'h00B, 12'h006, 12'h001, 12'h000, 12'h000};

        send_cmd(1, {12'hFFF, 12'h000, 12'h000}, 16'd0);
        for (int c = 1; c <= 821; c++) begin
            if (c > 1) @(negedge clk);
            exp_b    = (5 * (c - 1) > 4095) ? 12'hFFF : 12'(5 * (c - 1));
            exp_done = (c == 820);
            exp_busy = (c <= 819);
            n_cmp++;
            if ({r5, g5, b5, done5, busy5} !== {24'h0, exp_b, exp_done, exp_busy}) begin
                n_err++;
                $display("FAIL step5_blue c=%0d: got blu=%h red=%h grn=%h done=%b busy=%b expected blu=%h 0 0 done=%b busy=%b",
                         c, b5, r5, g5, done5, busy5, exp_b, exp_done, exp_busy);
            end
        end

        // Red 0 -> 0x00B: 5, 10, then the last step clamps to 11.
        @(negedge clk);
        send_cmd(1, {12'hFFF, 12'h000, 12'h00B}, 16'd0);
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge clk);
            n_cmp++;
            if ({r5, b5, done5, busy5} !== {up_tab[c-1], 12'hFFF, (c == 4), (c <= 3)}) begin
                n_err++;
                $display("FAIL step5_up c=%0d: got red=%h blu=%h done=%b busy=%b expected red=%h blu=fff",
                         c, r5, b5, done5, busy5, up_tab[c-1]);
            end
        end

        // Red 0x00B -> 0: 6, 1, then the last step clamps to 0 (no wrap).
        send_cmd(1, {12'hFFF, 12'h000, 12'h000}, 16'd0);
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) @(negedge clk);
            n_cmp++;
            if ({r5, b5, done5, busy5} !== {dn_tab[c-1], 12'hFFF, (c == 4), (c <= 3)}) begin
                n_err++;
                $display("FAIL step5_down c=%0d: got red=%h blu=%h done=%b busy=%b expected red=%h blu=fff",
                         c, r5, b5, done5, busy5, dn_tab[c-1]);
            end
        end
    endtask

    task automatic test_equal_cmd();
        n_cmp++;
        if ({rdy1, busy1} !== 2'b10) begin
            n_err++;
            $display("FAIL equal_pre: got rdy=%b busy=%b expected 1 0", rdy1, busy1);
        end
        send_cmd(0, {12'h000, 12'h000, 12'h0FE}, 16'd7);
        n_cmp++;
        if ({done1, busy1, rdy1, r1, st1} !== {3'b101, 12'h0FE, ST_IDLE}) begin
            n_err++;
            $display("FAIL equal_c1: got done=%b busy=%b rdy=%b red=%h expected 1 0 1 0fe",
                     done1, busy1, rdy1, r1);
        end
        @(negedge clk);
        n_cmp++;
        if ({done1, busy1, rdy1, r1} !== {3'b001, 12'h0FE}) begin
            n_err++;
            $display("FAIL equal_c2: got done=%b busy=%b rdy=%b red=%h expected 0 0 1 0fe",
                     done1, busy1, rdy1, r1);
        end
    endtask

    task automatic test_back_to_back();
        logic [LW-1:0] red_tab[10];
        logic [9:0] busy_tab, rdy_tab, done_tab;
        red_tab  = '{12'h0FE, 12'h0FE, 12'h0FD, 12'h0FD, 12'h0FC,
                     12'h0FC, 12'h0FD, 12'h0FE, 12'h0FF, 12'h0FF};
        // bit (c-1) is the expectation for cycle c
        busy_tab = 10'b00_1110_1111;
        rdy_tab  = 10'b11_0001_0000;
        done_tab = 10'b01_0001_0000;

        // Command A: red -> 0x0FC, rate 1.
        v1 = 1'b1; rgb1 = {12'h000, 12'h000, 12'h0FC}; rate1 = 16'd1;
        @(posedge clk);
        @(negedge clk);
        // Command B held throughout ramp A: red -> 0x0FF, rate 0.
        rgb1 = {12'h000, 12'h000, 12'h0FF}; rate1 = 16'd0;
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) @(negedge clk);
            n_cmp++;
            if ({r1, busy1, rdy1, done1} !== {red_tab[c-1], busy_tab[c-1], rdy_tab[c-1], done_tab[c-1]}) begin
                n_err++;
                $display("FAIL back_to_back c=%0d: got red=%h busy=%b rdy=%b done=%b expected red=%h busy=%b rdy=%b done=%b",
                         c, r1, busy1, rdy1, done1, red_tab[c-1], busy_tab[c-1], rdy_tab[c-1], done_tab[c-1]);
            end
            if (c == 6) v1 = 1'b0;
        end
    endtask

    task automatic test_reset_mid_ramp();
        bit seen;
        // Bring red to 0x080 first (127 steps down from 0x0FF).
        send_cmd(0, {12'h000, 12'h000, 12'h080}, 16'd0);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (done1) seen = 1'b1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!seen || r1 !== 12'h080) begin
            n_err++;
            $display("FAIL mid_setup: got done_seen=%b red=%h expected 1 080", seen, r1);
        end
        @(negedge clk);

        send_cmd(0, {12'h000, 12'h000, 12'h200}, 16'd0);
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({r1, busy1} !== {12'h084, 1'b1}) begin
            n_err++;
            $display("FAIL mid_progress: got red=%h busy=%b expected 084 1", r1, busy1);
        end

        #1 resetq = 1'b0;
        #1;
        n_cmp++;
        if ({r1, g1, b1, busy1, rdy1, done1, st1} !== {36'h0, 3'b010, ST_IDLE}) begin
            n_err++;
            $display("FAIL mid_reset_async: got lvls=%h busy=%b rdy=%b done=%b expected 0 0 1 0",
                     {r1, g1, b1}, busy1, rdy1, done1);
        end
        @(negedge clk);
        resetq = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({r1, busy1, rdy1, done1} !== {12'h000, 3'b010}) begin
                n_err++;
                $display("FAIL mid_after c=%0d: got red=%h busy=%b rdy=%b done=%b expected 000 0 1 0",
                         c, r1, busy1, rdy1, done1);
            end
        end

        send_cmd(0, {12'h000, 12'h000, 12'h003}, 16'd0);
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) @(negedge clk);
            n_cmp++;
            if ({r1, done1} !== {12'(c - 1), (c == 4)}) begin
                n_err++;
                $display("FAIL mid_restart c=%0d: got red=%h done=%b expected red=%h done=%b",
                         c, r1, done1, 12'(c - 1), (c == 4));
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_step_clamp();
        test_equal_cmd();
        test_back_to_back();
        test_reset_mid_ramp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
